display_renderer: RTL and testbench

//  Downstream consumer of the game_state 16x32 cell grid. On a start pulse it snapshots
//  the 512-bit display vector and scans it onto the 160x120 vga_adapter one pixel per

---
 rtl/display_renderer.sv | 143 ++++++++++++++
 tb/tb_display_renderer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/display_renderer.sv
// rtl/display_renderer.sv - scans a snapshotted 16x32 cell grid onto the 160x120 VGA adapter
module display_renderer #(
    parameter int         CELL_W    = 4,
    parameter int         CELL_H    = 3,
    parameter int         X_OFFSET  = 48,
    parameter int         Y_OFFSET  = 12,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [511:0] display,
    output logic         busy,
    output logic         done,
    output logic [7:0]   x,
    output logic [6:0]   y,
    output logic [2:0]   colour,
    output logic         plot
);

    // Sub-cell counters need at least one bit even for 1-pixel cells.
    localparam int SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [SXW-1:0] SX_LAST = SXW'(CELL_W - 1);
    localparam logic [SYW-1:0] SY_LAST = SYW'(CELL_H - 1);
    localparam logic [8:0]     X_START = 9'(X_OFFSET);
    localparam logic [8:0]     Y_START = 9'(Y_OFFSET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state;
    logic [511:0]   snap;
    logic [SXW-1:0] sx;
    logic [3:0]     cx;
    logic [SYW-1:0] sy;
    logic [4:0]     cy;
    logic [8:0]     px;
    logic [8:0]     py;

    logic sx_wrap;
    logic cx_wrap;
    logic sy_wrap;
    logic last_pixel;

    // Wrap detection for the nested row-major scan: sx, then cx, then sy, then cy.
    assign sx_wrap    = (sx == SX_LAST);
    assign cx_wrap    = (cx == 4'd15);
    assign sy_wrap    = (sy == SY_LAST);
    assign last_pixel = sx_wrap && cx_wrap && sy_wrap && (cy == 5'd31);

    // Frame sequencer: snapshot on start, one pixel per DRAW cycle, then a single done pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            snap   <= '0;
            sx     <= '0;
            cx     <= '0;
            sy     <= '0;
            cy     <= '0;
            px     <= '0;
            py     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        snap  <= display;
                        sx    <= '0;
                        cx    <= '0;
                        sy    <= '0;
                        cy    <= '0;
                        px    <= X_START;
                        py    <= Y_START;
                        busy  <= 1'b1;
                        state <= DRAW;
                    end
                end

                DRAW: begin
                    // The cell index cx*32+cy is just the concatenation {cx, cy}.
                    x      <= 8'(px);
                    y      <= 7'(py);
                    colour <= snap[{cx, cy}] ? FG_COLOUR : BG_COLOUR;
                    plot   <= 1'b1;

                    if (sx_wrap) begin
                        sx <= '0;
                        if (cx_wrap) begin
                            // End of a screen row: rewind x, step down one pixel row.
                            cx <= '0;
                            px <= X_START;
                            py <= py + 9'd1;
                            if (sy_wrap) begin
                                sy <= '0;
                                cy <= cy + 5'd1;
                            end else begin
                                sy <= sy + 1'b1;
                            end
                        end else begin
                            cx <= cx + 4'd1;
                            px <= px + 9'd1;
                        end
                    end else begin
                        sx <= sx + 1'b1;
                        px <= px + 9'd1;
                    end

                    if (last_pixel) begin
                        state <= FIN;
                    end
                end

                FIN: begin
                    plot  <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_renderer.sv
// tb/tb_display_renderer.sv - directed and randomized frame checks for display_renderer
module tb_display_renderer;

    localparam int CW = 4;
    localparam int CH = 3;
    localparam int XO = 48;
    localparam int YO = 12;
    localparam int P  = 512 * CW * CH;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [511:0] display;
    logic         busy;
    logic         done;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot;

    int vectors;
    int miscompares;

    int       fg_count;
    logic [14:0] first_xy;
    logic [14:0] last_xy;
    logic [2:0]  cap_a;
    logic [2:0]  cap_b;

    display_renderer #(
        .CELL_W(CW), .CELL_H(CH), .X_OFFSET(XO), .Y_OFFSET(YO),
        .FG_COLOUR(3'b111), .BG_COLOUR(3'b000)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .display(display),
        .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller has raised start before the E0 edge; returns at the negedge after the done cycle.
    // Pixel k of the frame is decomposed arithmetically into sub-cell/cell coordinates.
    task automatic run_frame(input string tag, input logic [511:0] model, input int inject_at);
        int sxv, cxv, syv, cyv, t, ex, ey;
        logic [2:0] ec;
        fg_count = 0;
        cap_a    = 3'bxxx;
        cap_b    = 3'bxxx;
        @(negedge clock);
        start = 1'b0;
        chk({tag, "_accept"}, {29'd0, plot, done, busy}, 32'b001);
        for (int k = 0; k < P; k++) begin
            @(negedge clock);
            sxv = k % CW;
            t   = k / CW;
            cxv = t % 16;
            t   = t / 16;
            syv = t % CH;
            cyv = t / CH;
            ex  = XO + cxv * CW + sxv;
            ey  = YO + cyv * CH + syv;
            ec  = model[cxv * 32 + cyv] ? 3'b111 : 3'b000;
            chk({tag, "_pix"}, {11'd0, plot, done, busy, x, y, colour},
                {11'd0, 1'b1, 1'b0, 1'b1, 8'(ex), 7'(ey), ec});
            if (colour === 3'b111) fg_count++;
            if (k == 0)     first_xy = {x, y};
            if (k == P - 1) last_xy  = {x, y};
            if (x == 8'd52 && y == 7'd15) cap_a = colour;
            if (x == 8'd56 && y == 7'd15) cap_b = colour;
            if (k == inject_at) begin
                display = '1;
                start   = 1'b1;
            end else if (k == inject_at + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clock);
        chk({tag, "_done"}, {29'd0, plot, done, busy}, 32'b010);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            chk({tag, "_idle"}, {29'd0, plot, done, busy}, 32'b000);
        end
    endtask

    initial begin
        logic [511:0] m;
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        start       = 1'b1;
        display     = '1;

        // Reset held with start asserted: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset", {12'd0, busy, done, x, y, colour, plot}, 32'd0);
        end
        resetn = 1'b1;
        start  = 1'b0;
        check_idle("post_reset", 2);

        // Blank frame with exact latency, extent and corner pixels.
        display = '0;
        start   = 1'b1;
        run_frame("blank", '0, -10);
        chk("blank_fg", 32'(fg_count), 32'd0);
        chk("blank_first", {17'd0, first_xy}, {17'd0, 8'd48, 7'd12});
        chk("blank_last", {17'd0, last_xy}, {17'd0, 8'd111, 7'd107});
        check_idle("blank", 3);

        // Single cell (3,10).
        m = '0;
        m[3 * 32 + 10] = 1'b1;
        display = m;
        start   = 1'b1;
        run_frame("single", m, -10);
        chk("single_fg", 32'(fg_count), 32'd12);
        check_idle("single", 2);

        // Snapshot/ignore, then a back-to-back start in the done cycle.
        display = '0;
        start   = 1'b1;
        run_frame("snap", '0, 100);
        chk("snap_fg", 32'(fg_count), 32'd0);
        start = 1'b1;
        run_frame("b2b", '1, -10);
        chk("b2b_fg", 32'(fg_count), 32'(P));
        check_idle("b2b", 3);
        chk("hold_xyc", {14'd0, x, y, colour}, {14'd0, 8'd111, 7'd107, 3'b111});

        // Checkerboard.
        for (int cx = 0; cx < 16; cx++)
            for (int cy = 0; cy < 32; cy++)
                m[cx * 32 + cy] = 1'((cx ^ cy) & 1);
        display = m;
        start   = 1'b1;
        run_frame("checker", m, -10);
        chk("cb_52_15", {29'd0, cap_a}, 32'd0);
        chk("cb_56_15", {29'd0, cap_b}, 32'd7);

        // Randomized grids.
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 16; w++) m[w * 32 +: 32] = $urandom;
            display = m;
            start   = 1'b1;
            run_frame("random", m, -10);
            check_idle("random", 1);
        end

        // Abort at pixel 1000: plot drops next cycle, no done afterwards.
        for (int w = 0; w < 16; w++) display[w * 32 +: 32] = $urandom;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 1000; k++) @(negedge clock);
        chk("abort_plotting", {31'd0, plot}, 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        chk("abort_reset", {12'd0, busy, done, x, y, colour, plot}, 32'd0);
        resetn = 1'b1;
        check_idle("abort", P);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
